// File: rtl/fetch_aligner_pkg.sv
// Shared fetch/decode definitions: halfword width, the compressed-parcel
// predicate and the fetch beat record.
package fetch_aligner_pkg;

  localparam int unsigned HALFWORD_W = 16;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_beat_t;

  // A parcel is compressed unless its two low bits are both set.
  function automatic logic is_compressed(input logic [HALFWORD_W-1:0] hw);
    return (hw & HALFWORD_W'(3)) != HALFWORD_W'(3);
  endfunction

endpackage

// File: rtl/fetch_aligner_halfword_queue.sv
// Four-entry halfword shift queue: up to two pushes and two pops per cycle.
// Entry 0 is the oldest halfword.
module halfword_queue
  import fetch_aligner_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [1:0]            push_i,
  input  logic [HALFWORD_W-1:0] push0_i,
  input  logic [HALFWORD_W-1:0] push1_i,
  input  logic [1:0]            pop_i,
  output logic [HALFWORD_W-1:0] hq0_o,
  output logic [HALFWORD_W-1:0] hq1_o,
  output logic [2:0]            count_o
);

  logic [3:0][HALFWORD_W-1:0] q_q, q_d;
  logic [2:0]                 count_q, count_d;
  logic [1:0]                 base;

  // Pop by shifting down, then append pushes after the surviving entries.
  always_comb begin
    q_d = q_q;
    unique case (pop_i)
      2'd1:    q_d = {{HALFWORD_W{1'b0}}, q_q[3:1]};
      2'd2:    q_d = {{(2*HALFWORD_W){1'b0}}, q_q[3:2]};
      default: q_d = q_q;
    endcase
    // Pushes only happen with count <= 2, so the 2-bit slot index suffices.
    base = count_q[1:0] - pop_i;
    if (push_i != 2'd0) q_d[base] = push0_i;
    if (push_i == 2'd2) q_d[base + 2'd1] = push1_i;
    count_d = count_q - {1'b0, pop_i} + {1'b0, push_i};
    if (clear_i) count_d = '0;
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q     <= '0;
      count_q <= '0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
    end
  end

  assign hq0_o   = q_q[0];
  assign hq1_o   = q_q[1];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_aligner.sv
// Instruction-fetch realignment: turns word-aligned fetch beats into a
// stream of 16/32-bit instructions with PCs, handling redirects and
// dropping stale beats by address.
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_addr,
  input  logic [31:0] fetch_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_is_compressed
);

  logic [31:0]           head_pc_q, head_pc_d;
  logic [31:0]           exp_addr_q, exp_addr_d;
  logic                  skip_low_q, skip_low_d;
  logic [HALFWORD_W-1:0] hq0, hq1, push0;
  logic [2:0]            count;
  logic [1:0]            push, pop;
  logic                  head_c, fire_in, take_beat, fire_out;
  fetch_beat_t           beat;

  assign beat = '{addr: fetch_addr, data: fetch_data};

  halfword_queue u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (flush),
    .push_i  (push),
    .push0_i (push0),
    .push1_i (beat.data[31:16]),
    .pop_i   (pop),
    .hq0_o   (hq0),
    .hq1_o   (hq1),
    .count_o (count)
  );

  // Handshakes and outputs; instr* come only from registered queue state.
  always_comb begin
    head_c      = is_compressed(hq0);
    fetch_ready = !flush && (count <= 3'd2);
    instr_valid = !flush && ((count >= 3'd2) || (count == 3'd1 && head_c));
    // Gated on occupancy so an empty queue reports a non-compressed zero.
    instr_is_compressed = (count != 3'd0) && head_c;
    instr    = instr_is_compressed ? {16'h0, hq0} : {hq1, hq0};
    instr_pc = head_pc_q;

    fire_in   = fetch_valid && fetch_ready;
    take_beat = fire_in && (beat.addr == exp_addr_q);
    fire_out  = instr_valid && instr_ready;

    push  = take_beat ? (skip_low_q ? 2'd1 : 2'd2) : 2'd0;
    push0 = skip_low_q ? beat.data[31:16] : beat.data[15:0];
    pop   = fire_out ? (head_c ? 2'd1 : 2'd2) : 2'd0;

    head_pc_d  = head_pc_q;
    exp_addr_d = exp_addr_q;
    skip_low_d = skip_low_q;
    if (flush) begin
      head_pc_d  = flush_pc & ~32'h1;
      exp_addr_d = flush_pc & ~32'h3;
      skip_low_d = flush_pc[1];
    end else begin
      if (fire_out) head_pc_d = head_pc_q + (head_c ? 32'd2 : 32'd4);
      if (take_beat) begin
        exp_addr_d = exp_addr_q + 32'd4;
        skip_low_d = 1'b0;
      end
    end
  end

  // PC tracking and expected fetch address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_pc_q  <= RESET_PC & ~32'h1;
      exp_addr_q <= RESET_PC & ~32'h3;
      skip_low_q <= RESET_PC[1];
    end else begin
      head_pc_q  <= head_pc_d;
      exp_addr_q <= exp_addr_d;
      skip_low_q <= skip_low_d;
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed self-checking bench for fetch_aligner.
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        fetch_valid = 1'b0;
  logic        fetch_ready;
  logic [31:0] fetch_addr = '0;
  logic [31:0] fetch_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_is_compressed;

  int total = 0;
  int bad = 0;

  fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .flush_pc            (flush_pc),
    .fetch_valid         (fetch_valid),
    .fetch_ready         (fetch_ready),
    .fetch_addr          (fetch_addr),
    .fetch_data          (fetch_data),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .instr               (instr),
    .instr_pc            (instr_pc),
    .instr_is_compressed (instr_is_compressed)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush = 1'b1;
    flush_pc = pc;
    step();
    flush = 1'b0;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d);
    fetch_valid = 1'b1;
    fetch_addr = a;
    fetch_data = d;
    step();
    fetch_valid = 1'b0;
  endtask

  task automatic take();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    settle();
    total++;
    if ({instr_valid, fetch_ready, instr, instr_pc, instr_is_compressed} !== {1'b0, 1'b1, 32'h0, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset: got v=%b rdy=%b instr=%h pc=%h c=%b want v=0 rdy=1 instr=0 pc=0 c=0",
               instr_valid, fetch_ready, instr, instr_pc, instr_is_compressed);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_32bit();
    fetch_valid = 1'b1;
    fetch_addr = 32'h0;
    fetch_data = 32'h00A0_0513;
    settle();
    total++;
    if ({fetch_ready, instr_valid} !== 2'b10) begin
      bad++;
      $display("FAIL w32_accept: got rdy=%b v=%b want rdy=1 v=0", fetch_ready, instr_valid);
    end
    step();
    fetch_valid = 1'b0;
    settle();
    total++;
    if ({instr_valid, instr, instr_pc, instr_is_compressed} !== {1'b1, 32'h00A0_0513, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL w32_emit: got v=%b instr=%h pc=%h c=%b want v=1 instr=00a00513 pc=0 c=0",
               instr_valid, instr, instr_pc, instr_is_compressed);
    end
    take();
    settle();
    total++;
    if ({instr_valid, instr_pc} !== {1'b0, 32'h4}) begin
      bad++;
      $display("FAIL w32_drain: got v=%b pc=%h want v=0 pc=4", instr_valid, instr_pc);
    end
  endtask

  task automatic test_mixed();
    logic [31:0] ei [3] = '{32'h0000_4501, 32'h00A0_0513, 32'h0000_1234};
    logic [31:0] ep [3] = '{32'h0, 32'h2, 32'h6};
    logic        ec [3] = '{1'b1, 1'b0, 1'b1};
    do_flush(32'h0);
    beat(32'h0, 32'h0513_4501);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        settle();
        total++;
        if (instr_valid !== 1'b0) begin
          bad++;
          $display("FAIL mixed_partial: got v=%b want v=0", instr_valid);
        end
        beat(32'h4, 32'h1234_00A0);
      end
      settle();
      total++;
      if ({instr_valid, instr, instr_pc, instr_is_compressed} !== {1'b1, ei[i], ep[i], ec[i]}) begin
        bad++;
        $display("FAIL mixed_emit%0d: got v=%b instr=%h pc=%h c=%b want v=1 instr=%h pc=%h c=%b",
                 i, instr_valid, instr, instr_pc, instr_is_compressed, ei[i], ep[i], ec[i]);
      end
      take();
    end
    settle();
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL mixed_empty: got v=%b want v=0", instr_valid);
    end
  endtask

  task automatic test_odd_redirect();
    do_flush(32'h102);
    beat(32'h100, 32'h4585_FFFF);
    settle();
    total++;
    if ({instr_valid, instr, instr_pc, instr_is_compressed} !== {1'b1, 32'h0000_4585, 32'h102, 1'b1}) begin
      bad++;
      $display("FAIL odd_emit: got v=%b instr=%h pc=%h c=%b want v=1 instr=00004585 pc=102 c=1",
               instr_valid, instr, instr_pc, instr_is_compressed);
    end
    take();
    settle();
    total++;
    if ({instr_valid, instr_pc} !== {1'b0, 32'h104}) begin
      bad++;
      $display("FAIL odd_drain: got v=%b pc=%h want v=0 pc=104", instr_valid, instr_pc);
    end
  endtask

  task automatic test_stale_wrap();
    logic [31:0] ei [4] = '{32'h1, 32'h2, 32'h4, 32'h8};
    logic [31:0] ep [4] = '{32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0, 32'h2};
    do_flush(32'h200);
    fetch_valid = 1'b1;
    fetch_addr = 32'h104;
    fetch_data = 32'h0001_0001;
    settle();
    total++;
    if (fetch_ready !== 1'b1) begin
      bad++;
      $display("FAIL stale_ready: got rdy=%b want rdy=1", fetch_ready);
    end
    step();
    fetch_valid = 1'b0;
    settle();
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL stale_drop: got v=%b want v=0", instr_valid);
    end
    beat(32'h200, 32'h0000_0013);
    settle();
    total++;
    if ({instr_valid, instr, instr_pc, instr_is_compressed} !== {1'b1, 32'h13, 32'h200, 1'b0}) begin
      bad++;
      $display("FAIL stale_emit: got v=%b instr=%h pc=%h c=%b want v=1 instr=00000013 pc=200 c=0",
               instr_valid, instr, instr_pc, instr_is_compressed);
    end
    do_flush(32'hFFFF_FFFC);
    beat(32'hFFFF_FFFC, 32'h0002_0001);
    fetch_valid = 1'b1;
    fetch_addr = 32'h0;
    fetch_data = 32'h0008_0004;
    settle();
    total++;
    if (fetch_ready !== 1'b1) begin
      bad++;
      $display("FAIL wrap_ready: got rdy=%b want rdy=1", fetch_ready);
    end
    step();
    fetch_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      total++;
      if ({instr_valid, instr, instr_pc, instr_is_compressed} !== {1'b1, ei[i], ep[i], 1'b1}) begin
        bad++;
        $display("FAIL wrap_emit%0d: got v=%b instr=%h pc=%h c=%b want v=1 instr=%h pc=%h c=1",
                 i, instr_valid, instr, instr_pc, instr_is_compressed, ei[i], ep[i]);
      end
      take();
    end
    settle();
    total++;
    if ({instr_valid, instr_pc} !== {1'b0, 32'h4}) begin
      bad++;
      $display("FAIL wrap_drain: got v=%b pc=%h want v=0 pc=4", instr_valid, instr_pc);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    do_flush(32'h300);
    fetch_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fetch_addr = 32'h300 + 32'(4 * acc);
      fetch_data = 32'h1000_0013 + 32'(acc << 20);
      settle();
      if (fetch_ready) acc++;
      step();
    end
    fetch_valid = 1'b0;
    settle();
    total++;
    if (acc !== 2 || fetch_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_accepted: got beats=%0d rdy=%b want beats=2 rdy=0", acc, fetch_ready);
    end
    instr_ready = 1'b1;
    settle();
    total++;
    if ({instr_valid, instr, instr_pc, fetch_ready} !== {1'b1, 32'h1000_0013, 32'h300, 1'b0}) begin
      bad++;
      $display("FAIL bp_drain0: got v=%b instr=%h pc=%h rdy=%b want v=1 instr=10000013 pc=300 rdy=0",
               instr_valid, instr, instr_pc, fetch_ready);
    end
    step();
    settle();
    total++;
    if ({instr_valid, instr, instr_pc, fetch_ready} !== {1'b1, 32'h1010_0013, 32'h304, 1'b1}) begin
      bad++;
      $display("FAIL bp_drain1: got v=%b instr=%h pc=%h rdy=%b want v=1 instr=10100013 pc=304 rdy=1",
               instr_valid, instr, instr_pc, fetch_ready);
    end
    step();
    instr_ready = 1'b0;
    settle();
    total++;
    if ({instr_valid, instr_pc} !== {1'b0, 32'h308}) begin
      bad++;
      $display("FAIL bp_empty: got v=%b pc=%h want v=0 pc=308", instr_valid, instr_pc);
    end
  endtask

  task automatic test_flush_collision();
    do_flush(32'h400);
    beat(32'h400, 32'h0000_0013);
    flush = 1'b1;
    flush_pc = 32'h500;
    fetch_valid = 1'b1;
    fetch_addr = 32'h404;
    fetch_data = 32'h0001_0001;
    instr_ready = 1'b1;
    settle();
    total++;
    if ({instr_valid, fetch_ready} !== 2'b00) begin
      bad++;
      $display("FAIL coll_gate: got v=%b rdy=%b want v=0 rdy=0", instr_valid, fetch_ready);
    end
    step();
    flush = 1'b0;
    fetch_valid = 1'b0;
    instr_ready = 1'b0;
    settle();
    total++;
    if ({instr_valid, instr_pc, fetch_ready} !== {1'b0, 32'h500, 1'b1}) begin
      bad++;
      $display("FAIL coll_after: got v=%b pc=%h rdy=%b want v=0 pc=500 rdy=1",
               instr_valid, instr_pc, fetch_ready);
    end
    beat(32'h500, 32'h0001_4501);
    settle();
    total++;
    if ({instr_valid, instr, instr_pc, instr_is_compressed} !== {1'b1, 32'h4501, 32'h500, 1'b1}) begin
      bad++;
      $display("FAIL coll_emit: got v=%b instr=%h pc=%h c=%b want v=1 instr=00004501 pc=500 c=1",
               instr_valid, instr, instr_pc, instr_is_compressed);
    end
  endtask

  initial begin
    test_reset();
    test_32bit();
    test_mixed();
    test_odd_redirect();
    test_stale_wrap();
    test_backpressure();
    test_flush_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_aligner.md
# fetch_aligner

Instruction-fetch realignment stage between the word-aligned instruction memory port and `IR_Decompression`. It consumes 32-bit word-aligned fetch beats and buffers them as a 16-bit halfword queue. It emits one instruction per handshake: either a 16-bit compressed parcel or a 32-bit instruction, which may straddle two fetch words, together with its PC. It also handles redirects (flushes) to halfword-aligned targets and drops stale in-flight fetch words.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC of the first emitted instruction after reset; bit 0 ignored.
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  redirect request; highest priority.
- `flush_pc`  in  32  redirect target; bit 0 ignored.
- `fetch_valid`  in  1  fetch beat valid.
- `fetch_ready`  out  1  aligner can accept a beat.
- `fetch_addr`  in  32  byte address of the beat; word aligned.
- `fetch_data`  in  32  fetched word; little-endian, halfword 0 is `[15:0]`.
- `instr_valid`  out  1  `instr` holds a complete instruction.
- `instr_ready`  in  1  downstream (decompress/decode) accepts.
- `instr`  out  32  raw instruction; compressed parcels are zero-extended to `{16'h0, hw}`.
- `instr_pc`  out  32  byte address of `instr`.
- `instr_is_compressed`  out  1  `instr[1:0] != 2'b11`.

## Operation
- **State.**
  - Halfword queue `hq[0..3]` with `count` 0..4.
  - `head_pc`, the PC of `hq[0]`.
  - `exp_addr`, the next expected fetch word address.
  - `skip_low`, which discards the lower halfword of the next matching beat.
- **Reset.**
  - `count=0`, `head_pc=RESET_PC & ~1`, `exp_addr=RESET_PC & ~3`, `skip_low=RESET_PC[1]`.
  - Outputs at reset: `instr_valid=0`, `fetch_ready=1`, `instr=0`, `instr_pc=RESET_PC & ~1`, `instr_is_compressed=0`.
- **Accept.**
  - `fetch_ready = !flush && count <= 2`; this does not depend on `instr_ready`.
  - A beat transfers on `fetch_valid && fetch_ready`.
  - If `fetch_addr != exp_addr`, the beat is consumed and dropped; no other state changes.
  - Otherwise the beat pushes `fetch_data[15:0]` (unless `skip_low`) and then `fetch_data[31:16]`. `skip_low` clears and `exp_addr += 4`.
- **Emit.**
  - `c = hq[0][1:0] != 2'b11`.
  - `instr_valid = !flush && (count >= 2 || (count == 1 && c))`.
  - `instr = c ? {16'h0, hq[0]} : {hq[1], hq[0]}`.
  - On handshake, 1 halfword (if `c`) or 2 are popped and `head_pc += 2 or 4`.
- **Simultaneous push and pop.** `count_next = count - pop + push` and the queue shifts accordingly. The `count <= 2` gate guarantees no overflow.
- **Flush.**
  - Both handshakes in the flush cycle are cancelled.
  - Next state: `count=0`, `head_pc=flush_pc & ~1`, `exp_addr=flush_pc & ~3`, `skip_low=flush_pc[1]`.
  - Beats still returning for old addresses are then dropped by the address check.
- **Arithmetic.** All address/PC arithmetic is mod 2^32; `0xFFFF_FFFC + 4` wraps to `0`.
- **Decode scope.** The aligner does not decode beyond `[1:0]`. It never flags illegal instructions; `IR_Decompression` and the decoder own that.

## Timing
- Beat accepted at edge N: the instruction it completes is visible at `instr_valid` in cycle N+1. The same holds for the tail of a straddling instruction.
- `instr*` outputs are driven from registered queue state only. There is no combinational path from `fetch_*` to `instr*`.
- The only combinational inputs on outputs are `flush` to `instr_valid`/`fetch_ready` gating, and `instr_ready`, which does not reach `fetch_ready`.
- Sustained throughput: one instruction per cycle for all-32-bit or all-16-bit streams.
  - All-16-bit streams drain 1 halfword/cycle, so fetch stalls every other beat.
- `rst` mid-operation: immediate return to reset values regardless of pending handshakes.

## Structure
- Shared core package holds:
  - `HALFWORD_W = 16`.
  - The `is_compressed(hw)` predicate function, reused by `IR_Decompression`'s `[1:0] != 2'b11` check.
  - The `fetch_beat_t` struct `{addr, data}`.
- One natural sub-module: `halfword_queue`, a 4-entry shift queue with 0/1/2 push and 0/1/2 pop per cycle and a `count` output. The aligner wraps it with PC tracking, the address filter and flush.

## Test plan
- **32-bit only.** `RESET_PC=0`, beat `@0x0 = 0x00A0_0513` → cycle after accept: `instr=0x00A00513`, `instr_pc=0x0`, compressed 0.
- **Mixed and straddle.** Beat `@0x0 = 0x0513_4501`, then `@0x4 = 0x1234_00A0` → emits, in order:
  - `0x00004501` at pc 0, compressed 1;
  - `0x00A00513` at pc 2, compressed 0;
  - `0x00001234` at pc 6, compressed 1.
- **Odd redirect.** Flush to `0x102`, beat `@0x100 = 0x4585_FFFF` → lower half discarded; emits `0x00004585` at pc `0x102`.
- **Stale drop and wrap.**
  - Flush to `0x200`, then beat `@0x104` → `fetch_ready=1`, beat dropped, no `instr_valid`. Beat `@0x200 = 0x0000_0013` → `0x00000013` at pc `0x200`.
  - Separately, flush to `0xFFFF_FFFC` with beats at `0xFFFF_FFFC` and `0x0` → second beat accepted (`exp_addr` wrapped).
- **Backpressure.** `instr_ready=0`, continuous 32-bit beats → exactly 2 beats accepted, then `fetch_ready=0` with count 4. Raising `instr_ready` drains one instruction per cycle, and `fetch_ready` reasserts once count ≤ 2.
- **Flush collision.** With `instr_valid=1`, assert `flush` in the same cycle as `fetch_valid` and `instr_ready` → no transfer on either side that cycle; next output is from `flush_pc`.
